// File: rtl/bias_pkg.sv
// Shared widths, FIFO geometry and FSM state encoding for the bias fetch block.
package bias_pkg;

  localparam int unsigned BIAS_D_WIDTH = 16;
  localparam int unsigned BIAS_A_WIDTH = 4;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_AW    = 2;
  localparam int unsigned FIFO_CW    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bias_fetch_fifo.sv
// Depth-4 shift-register FIFO; the head entry is always slot 0 so the output is
// a flop, and popped slots are back-filled with zeros.
module bias_fetch_fifo
  import bias_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic               valid,
  output logic [FIFO_CW-1:0] occ
);

  logic [W-1:0]       mem     [FIFO_DEPTH];
  logic [W-1:0]       mem_nxt [FIFO_DEPTH];
  logic [FIFO_CW-1:0] occ_nxt;
  logic [FIFO_CW-1:0] wr_idx;
  logic               do_pop;
  logic               do_push;

  always_comb begin
    do_pop  = pop && (occ != '0);
    do_push = push && ((occ != FIFO_CW'(FIFO_DEPTH)) || do_pop);
    for (int i = 0; i < FIFO_DEPTH; i++) mem_nxt[i] = mem[i];
    if (do_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
      mem_nxt[FIFO_DEPTH-1] = '0;
    end
    wr_idx = do_pop ? (occ - FIFO_CW'(1)) : occ;
    if (do_push) mem_nxt[wr_idx[FIFO_AW-1:0]] = push_data;
    occ_nxt = occ + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      occ   <= '0;
      valid <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= mem_nxt[i];
      occ   <= occ_nxt;
      valid <= (occ_nxt != '0);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/bias_fetch.sv
// Streams cnt bias words from a registered-address RAM starting at base_addr.
// Optional out_last marking is enabled by defining BIAS_FETCH_LAST_EN.
module bias_fetch
  import bias_pkg::*;
#(
  parameter int unsigned D_WIDTH = BIAS_D_WIDTH,
  parameter int unsigned A_WIDTH = BIAS_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   cnt,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_data,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

`ifdef BIAS_FETCH_LAST_EN
  localparam int unsigned E_WIDTH = D_WIDTH + 1;
`else
  localparam int unsigned E_WIDTH = D_WIDTH;
`endif
  localparam int unsigned C_WIDTH = A_WIDTH + 1;

  state_e             state, state_nxt;
  logic [A_WIDTH-1:0] r_addr_nxt;
  logic [C_WIDTH-1:0] issue_left, issue_left_nxt;
  logic [C_WIDTH-1:0] xfer_left, xfer_left_nxt;
  logic               done_nxt;
  logic               issue, issue_last;
  logic               p1, p2;
  logic               xfer, room;
  logic [FIFO_CW-1:0] occ;
  logic [FIFO_CW-1:0] in_flight;
  logic [E_WIDTH-1:0] push_data;
  logic [E_WIDTH-1:0] head;

  // Reads returning within two cycles count against FIFO space before issue.
  always_comb begin
    xfer      = out_valid && out_ready;
    in_flight = FIFO_CW'(p1) + FIFO_CW'(p2);
    room      = (occ + in_flight) < FIFO_CW'(FIFO_DEPTH);
  end

  always_comb begin
    state_nxt      = state;
    r_addr_nxt     = r_addr;
    issue_left_nxt = issue_left;
    xfer_left_nxt  = xfer ? (xfer_left - C_WIDTH'(1)) : xfer_left;
    done_nxt       = 1'b0;
    issue          = 1'b0;
    issue_last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cnt == '0) begin
            done_nxt = 1'b1;
          end else begin
            // First address goes out with start so data lands two cycles later.
            issue          = 1'b1;
            issue_last     = (cnt == C_WIDTH'(1));
            r_addr_nxt     = base_addr;
            issue_left_nxt = cnt - C_WIDTH'(1);
            xfer_left_nxt  = cnt;
            state_nxt      = issue_last ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (room) begin
          issue          = 1'b1;
          issue_last     = (issue_left == C_WIDTH'(1));
          r_addr_nxt     = r_addr + A_WIDTH'(1);
          issue_left_nxt = issue_left - C_WIDTH'(1);
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && (xfer_left == C_WIDTH'(1))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BIAS_FETCH_LAST_EN
  logic p1_last, p2_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      r_addr     <= '0;
      issue_left <= '0;
      xfer_left  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      p1         <= 1'b0;
      p2         <= 1'b0;
`ifdef BIAS_FETCH_LAST_EN
      p1_last    <= 1'b0;
      p2_last    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      r_addr     <= r_addr_nxt;
      issue_left <= issue_left_nxt;
      xfer_left  <= xfer_left_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      p1         <= issue;
      p2         <= p1;
`ifdef BIAS_FETCH_LAST_EN
      p1_last    <= issue_last;
      p2_last    <= p1_last;
`endif
    end
  end

`ifdef BIAS_FETCH_LAST_EN
  assign push_data = {p2_last, ram_data};
  assign out_last  = head[D_WIDTH];
`else
  assign push_data = ram_data;
  assign out_last  = 1'b0;
`endif
  assign out_data = head[D_WIDTH-1:0];

  bias_fetch_fifo #(.W(E_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (p2),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (head),
    .valid     (out_valid),
    .occ       (occ)
  );

endmodule
